// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg
// Shared types and helpers for the sequential binary-to-BCD converter.
//   bcd_digit_t  : one packed BCD digit
//   conv_state_t : converter FSM states
//   min_digits() : decimal digits needed to show 2^bin_w - 1
package bin2bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } conv_state_t;

    // Number of decimal digits in the largest BIN_W-bit value.
    function automatic int min_digits(input int bin_w);
        longint unsigned v;
        int              n;
        if (bin_w >= 64) begin
            return 20;
        end
        v = (64'd1 << bin_w) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_dabble_digit.sv
// dabble_digit
// Combinational add-3 correction for one BCD digit of the double-dabble
// accumulator: digits 5..9 get +3 so that the following left shift carries
// into the next digit exactly when the doubled value reaches 10.
//   i_digit : accumulator digit before correction
//   o_digit : corrected digit (4-bit arithmetic)
module dabble_digit
    import bin2bcd_pkg::*;
(
    input  bcd_digit_t i_digit,
    output bcd_digit_t o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit > 4'd4) begin
            o_digit = i_digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// A conversion accepted on edge E0 finishes on edge E(BIN_W) with a one-cycle
// o_done pulse; o_bcd / o_blank then hold until the next completed conversion.
//
// Optional feature macro: BIN2BCD_BLANK_EN
//   defined   : o_blank is the leading-zero blank mask registered with o_bcd
//   undefined : o_blank is tied to zero
//
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset
//   i_start : conversion request, sampled only while idle
//   i_bin   : binary value, captured on the accepting edge
//   o_busy  : conversion in progress
//   o_done  : one-cycle completion pulse
//   o_bcd   : packed BCD result, digit 0 in bits [3:0]
//   o_blank : leading-zero blank mask, bit i blanks digit i
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_bin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic [DIGITS-1:0]     o_blank
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    // Elaboration-time parameter checks.
    if (BIN_W < 4) begin : g_bad_bin_w
        $error("bin2bcd_seq: BIN_W must be >= 4");
    end
    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for BIN_W");
    end

    conv_state_t           r_state;
    logic [BIN_W-1:0]      r_sreg;
    logic [4*DIGITS-1:0]   r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic [4*DIGITS-1:0]   r_bcd;

    logic [4*DIGITS-1:0]   w_adj;
    logic [4*DIGITS-1:0]   w_acc_next;
    logic                  w_unused_msb;

    // Per-digit add-3 correction ahead of the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        dabble_digit u_digit (
            .i_digit (r_acc[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    // Shift {acc, sreg} left by one; the MSB of the corrected accumulator is
    // always zero because DIGITS covers the full input range.
    assign w_acc_next   = {w_adj[4*DIGITS-2:0], r_sreg[BIN_W-1]};
    assign w_unused_msb = w_adj[4*DIGITS-1];

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank_next;

    // Digit i is blanked when it and every digit above it are zero; digit 0
    // is never blanked so a zero result still shows "0".
    always_comb begin
        logic v_zero;
        w_blank_next = '0;
        v_zero       = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            v_zero          = v_zero && (w_acc_next[4*i +: 4] == 4'd0);
            w_blank_next[i] = v_zero;
        end
    end

    assign o_blank = r_blank;
`else
    assign o_blank = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
`ifdef BIN2BCD_BLANK_EN
            r_blank <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_sreg  <= i_bin;
                        r_acc   <= '0;
                        r_cnt   <= CNT_W'(BIN_W - 1);
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_acc  <= w_acc_next;
                    r_sreg <= {r_sreg[BIN_W-2:0], 1'b0};
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_bcd   <= w_acc_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
`ifdef BIN2BCD_BLANK_EN
                        r_blank <= w_blank_next;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_bcd  = r_bcd;

endmodule
